// File: rtl/alu_usub_seq_if.sv
// Valid/ready operand and result channel for the sequential unsigned subtractor.
interface alu_usub_seq_if #(
  parameter int SIZE = 8
);
  logic            i_valid;
  logic            o_ready;
  logic [SIZE-1:0] i_s1;
  logic [SIZE-1:0] i_s2;
  logic            o_valid;
  logic            i_ready;
  logic [SIZE-1:0] o_result;
  logic            o_borrow;

  modport master (
    output i_valid, i_s1, i_s2, i_ready,
    input  o_ready, o_valid, o_result, o_borrow
  );

  modport slave (
    input  i_valid, i_s1, i_s2, i_ready,
    output o_ready, o_valid, o_result, o_borrow
  );
endinterface

// File: rtl/alu_usub_seq.sv
// Multi-cycle unsigned subtractor: s1 - s2 mod 2^SIZE, CHUNK bits per cycle, LSB chunk first.
//   state | meaning
//   IDLE  | ready for operands
//   RUN   | one chunk of the difference per cycle, borrow carried in a register
//   DONE  | result held until downstream accepts
module alu_usub_seq #(
  parameter int SIZE  = 8,
  parameter int CHUNK = 2
) (
  input logic            i_clk,
  input logic            i_rst_n,
  alu_usub_seq_if.slave  bus
);
  localparam int NCH   = SIZE / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [SIZE-1:0]   a_sh, b_sh, res;
  logic              bin;
  logic [CNT_W-1:0]  cnt;
  logic              last_chunk;
  logic [CHUNK:0]    diff;
  logic [SIZE-1:0]   diff_ext;

  assign last_chunk = (cnt == CNT_W'(NCH - 1));

  // Extra top bit of diff is the borrow out of this chunk.
  always_comb begin
    diff     = {1'b0, a_sh[CHUNK-1:0]} - {1'b0, b_sh[CHUNK-1:0]} - {{CHUNK{1'b0}}, bin};
    diff_ext = SIZE'(diff[CHUNK-1:0]);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_valid) state_nxt = RUN;
      RUN:     if (last_chunk)  state_nxt = DONE;
      DONE:    if (bus.i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      bin  <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            a_sh <= bus.i_s1;
            b_sh <= bus.i_s2;
            bin  <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> CHUNK;
          b_sh <= b_sh >> CHUNK;
          res  <= (res >> CHUNK) | (diff_ext << (SIZE - CHUNK));
          bin  <= diff[CHUNK];
          cnt  <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready  = (state == IDLE);
  assign bus.o_valid  = (state == DONE);
  assign bus.o_result = res;
  assign bus.o_borrow = bin;
endmodule

// File: tb/tb_alu_usub_seq.sv
// Scoreboard bench: directed cases on the default build plus a random sweep over several CHUNK/SIZE builds.
module tb_alu_usub_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int sw_finished = 0;
  bit m_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic int sw_size(input int g);
    return (g == 4) ? 16 : 8;
  endfunction

  function automatic int sw_chunk(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      3:       return 8;
      default: return 4;
    endcase
  endfunction

  // ---------------- default build, directed cases ----------------
  alu_usub_seq_if #(.SIZE(8)) m_bus();
  logic m_rst_n;
  alu_usub_seq #(.SIZE(8), .CHUNK(2)) u_main (.i_clk(clk), .i_rst_n(m_rst_n), .bus(m_bus));

  logic [8:0] m_exp[$];
  int         m_acc[$];
  bit         m_prev_valid = 1'b0;
  logic [8:0] m_e;

  always @(negedge clk) begin
    if (!m_rst_n) m_prev_valid = 1'b0;
    else begin
      if (m_bus.o_valid && !m_prev_valid) begin
        if (m_acc.size() == 0) fail_now("main_spurious_valid");
        else chk("main_latency", 32'(cyc - m_acc[0]), 32'd4);
      end
      if (m_bus.o_valid && m_bus.i_ready) begin
        if (m_exp.size() == 0) fail_now("main_unexpected_result");
        else begin
          m_e = m_exp.pop_front();
          void'(m_acc.pop_front());
          chk("main_result", 32'(m_bus.o_result), 32'(m_e[7:0]));
          chk("main_borrow", 32'(m_bus.o_borrow), 32'(m_e[8]));
        end
      end
      m_prev_valid = m_bus.o_valid;
    end
  end

  task automatic m_issue(input logic [7:0] s1, input logic [7:0] s2);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    m_bus.i_valid = 1'b1;
    m_bus.i_s1 = s1;
    m_bus.i_s2 = s2;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (m_bus.o_ready) begin
        m_exp.push_back({s1 < s2, 8'(s1 - s2)});
        m_acc.push_back(cyc + 1);
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("main_accept_timeout");
    @(posedge clk); #1;
    m_bus.i_valid = 1'b0;
  endtask

  task automatic m_wait_hs();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (m_bus.o_valid && m_bus.i_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("main_handshake_timeout");
  endtask

  task automatic m_op(input logic [7:0] s1, input logic [7:0] s2);
    m_issue(s1, s2);
    m_wait_hs();
    @(negedge clk);
    chk("main_ready_after_hs", 32'(m_bus.o_ready), 32'd1);
    chk("main_valid_drop", 32'(m_bus.o_valid), 32'd0);
  endtask

  task automatic m_check_cleared(input string tag);
    chk({tag, "_ready"},  32'(m_bus.o_ready),  32'd1);
    chk({tag, "_valid"},  32'(m_bus.o_valid),  32'd0);
    chk({tag, "_result"}, 32'(m_bus.o_result), 32'd0);
    chk({tag, "_borrow"}, 32'(m_bus.o_borrow), 32'd0);
  endtask

  initial begin
    bit got;
    m_rst_n = 1'b0;
    m_bus.i_valid = 1'b0;
    m_bus.i_ready = 1'b1;
    m_bus.i_s1 = '0;
    m_bus.i_s2 = '0;
    repeat (3) @(posedge clk);
    #1 m_rst_n = 1'b1;
    @(negedge clk);
    m_check_cleared("reset");

    m_op(8'd200, 8'd55);
    m_op(8'd55, 8'd200);
    m_op(8'd0, 8'd1);
    m_op(8'h5A, 8'h5A);
    m_op(8'd255, 8'd0);
    m_op(8'd0, 8'd255);

    // backpressure with stray operands offered while busy
    m_bus.i_ready = 1'b0;
    m_issue(8'h9C, 8'h31);
    m_bus.i_valid = 1'b1;
    m_bus.i_s1 = 8'h11;
    m_bus.i_s2 = 8'h22;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_bus.o_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("bp_valid_timeout");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid_hold",  32'(m_bus.o_valid),  32'd1);
      chk("bp_result_hold", 32'(m_bus.o_result), 32'h6B);
      chk("bp_borrow_hold", 32'(m_bus.o_borrow), 32'd0);
    end
    @(posedge clk); #1;
    m_bus.i_valid = 1'b0;
    m_bus.i_ready = 1'b1;
    m_wait_hs();
    @(negedge clk);
    chk("bp_ready_after", 32'(m_bus.o_ready), 32'd1);
    @(negedge clk);
    chk("bp_no_capture", 32'(m_bus.o_valid), 32'd0);

    // reset landing on the edge that processes chunk 2
    m_issue(8'd100, 8'd1);
    @(posedge clk);
    @(posedge clk); #1;
    m_rst_n = 1'b0;
    @(posedge clk); #1;
    m_rst_n = 1'b1;
    m_exp.delete();
    m_acc.delete();
    @(negedge clk);
    m_check_cleared("midreset");
    m_op(8'd10, 8'd3);
    repeat (10) @(negedge clk);
    chk("main_queue_empty", 32'(m_exp.size()), 32'd0);
    m_done = 1'b1;
  end

  // ---------------- random sweep over builds ----------------
  for (genvar g = 0; g < 5; g++) begin : g_sw
    localparam int S = sw_size(g);
    localparam int C = sw_chunk(g);
    localparam int L = S / C;

    alu_usub_seq_if #(.SIZE(S)) bus();
    logic rst_n;
    alu_usub_seq #(.SIZE(S), .CHUNK(C)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    logic [S:0]   exp_q[$];
    int           acc_q[$];
    bit           prev_valid = 1'b0;
    logic [S:0]   e;
    logic [S-1:0] sa, sb;

    always @(posedge clk) begin
      #1 bus.i_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
      if (!rst_n) prev_valid = 1'b0;
      else begin
        if (bus.o_valid && !prev_valid) begin
          if (acc_q.size() == 0) fail_now($sformatf("sw%0d_spurious_valid", g));
          else chk($sformatf("sw%0d_latency", g), 32'(cyc - acc_q[0]), 32'(L));
        end
        if (bus.o_valid && bus.i_ready) begin
          if (exp_q.size() == 0) fail_now($sformatf("sw%0d_unexpected_result", g));
          else begin
            e = exp_q.pop_front();
            void'(acc_q.pop_front());
            chk($sformatf("sw%0d_result", g), 32'(bus.o_result), 32'(e[S-1:0]));
            chk($sformatf("sw%0d_borrow", g), 32'(bus.o_borrow), 32'(e[S]));
          end
        end
        prev_valid = bus.o_valid;
      end
    end

    initial begin
      bit got;
      rst_n = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_s1 = '0;
      bus.i_s2 = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int n = 0; n < 1000; n++) begin
        sa = S'($urandom);
        sb = S'($urandom);
        case ($urandom_range(0, 7))
          0: sb = sa;
          1: sa = '0;
          2: sb = '1;
          3: sa = '1;
          default: ;
        endcase
        @(posedge clk); #1;
        bus.i_valid = 1'b1;
        bus.i_s1 = sa;
        bus.i_s2 = sb;
        got = 1'b0;
        for (int k = 0; k < 4 * L + 40; k++) begin
          @(negedge clk);
          if (bus.o_ready) begin
            exp_q.push_back({sa < sb, S'(sa - sb)});
            acc_q.push_back(cyc + 1);
            got = 1'b1;
            break;
          end
        end
        if (!got) begin
          fail_now($sformatf("sw%0d_accept_timeout", g));
          break;
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_s1 = S'($urandom);
        bus.i_s2 = S'($urandom);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      for (int k = 0; k < 400; k++) begin
        if (exp_q.size() == 0) break;
        @(negedge clk);
      end
      chk($sformatf("sw%0d_drained", g), 32'(exp_q.size()), 32'd0);
      sw_finished++;
    end
  end

  initial begin
    for (int k = 0; k < 60000; k++) begin
      @(negedge clk);
      if (m_done && sw_finished == 5) break;
    end
    chk("all_done", 32'({m_done, sw_finished == 5}), 32'd3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
